// File: rtl/sdram_aref_sched.sv
// SDRAM auto-refresh scheduler: interval ticks feed a saturating refresh debt, drained by AREF bursts on grant.
// Define SDRAM_AREF_PREALL_EN to prefix every burst with PRECHARGE ALL.
module sdram_aref_sched #(
   parameter int REF_INTERVAL = 1500,
   parameter int AREF_NUM     = 1,
   parameter int T_RP         = 2,
   parameter int T_RFC        = 7,
   parameter int MAX_DEBT     = 8,
   parameter int URGENT_TH    = 6,
   parameter int ADDR_W       = 13
) (
   input  logic                              sclk,
   input  logic                              s_rst,
   input  logic                              flag_init_end,
   input  logic                              ref_en,
   output logic                              ref_req,
   output logic                              ref_urgent,
   output logic                              ref_ovf,
   output logic                              flag_ref_end,
   output logic [$clog2(MAX_DEBT+1)-1:0]     ref_debt,
   output logic [3:0]                        aref_cmd,
   output logic [ADDR_W-1:0]                 sdram_addr
);
   localparam int CNT_W    = $clog2(REF_INTERVAL);
   localparam int DEBT_W   = $clog2(MAX_DEBT+1);
   localparam int N_W      = $clog2(AREF_NUM+1);
   localparam int WAIT_MAX = (T_RP > T_RFC) ? T_RP : T_RFC;
   localparam int WAIT_W   = $clog2(WAIT_MAX+1);

   localparam logic [3:0] CMD_NOP  = 4'b0111;
   localparam logic [3:0] CMD_PRE  = 4'b0010;
   localparam logic [3:0] CMD_AREF = 4'b0001;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_PRE       = 3'd1;
   localparam logic [2:0] S_PRE_WAIT  = 3'd2;
   localparam logic [2:0] S_AREF      = 3'd3;
   localparam logic [2:0] S_AREF_WAIT = 3'd4;
   localparam logic [2:0] S_DONE      = 3'd5;
`ifdef SDRAM_AREF_PREALL_EN
   localparam logic [2:0] S_FIRST     = S_PRE;
`else
   localparam logic [2:0] S_FIRST     = S_AREF;
`endif

   logic [CNT_W-1:0]  r_cnt;
   logic [DEBT_W-1:0] r_debt;
   logic              r_ovf;
   logic [2:0]        r_state;
   logic [3:0]        r_cmd;
   logic [WAIT_W-1:0] r_wait;
   logic [N_W-1:0]    r_n;
   logic [N_W-1:0]    r_issued;
   logic [2:0]        w_state_next;
   logic              w_tick;
   logic              w_grant;
   logic              w_wait_done;
   logic              w_more;
   logic              w_ovf_set;
   int                w_debt_calc;

   assign w_tick      = flag_init_end && (r_cnt == CNT_W'(REF_INTERVAL-1));
   assign w_grant     = (r_state == S_IDLE) && ref_en && (r_debt != '0);
   assign w_more      = (r_issued < r_n);
   assign w_wait_done = (r_state == S_PRE_WAIT) ? (int'(r_wait) >= T_RP-2)
                                                : (int'(r_wait) >= T_RFC-2);

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:      if (w_grant) w_state_next = S_FIRST;
         S_PRE:       w_state_next = (T_RP > 1) ? S_PRE_WAIT : S_AREF;
         S_PRE_WAIT:  if (w_wait_done) w_state_next = S_AREF;
         S_AREF:      w_state_next = (T_RFC > 1) ? S_AREF_WAIT : (w_more ? S_AREF : S_DONE);
         S_AREF_WAIT: if (w_wait_done) w_state_next = w_more ? S_AREF : S_DONE;
         S_DONE:      w_state_next = S_IDLE;
         default:     w_state_next = S_IDLE;
      endcase
   end

   // Completion and a tick may land together; the increment is applied after the drain.
   always_comb begin
      w_debt_calc = int'(r_debt);
      w_ovf_set   = 1'b0;
      if (r_state == S_DONE)
         w_debt_calc = (w_debt_calc > int'(r_n)) ? w_debt_calc - int'(r_n) : 0;
      if (w_tick) begin
         if (w_debt_calc == MAX_DEBT) w_ovf_set = 1'b1;
         else                         w_debt_calc = w_debt_calc + 1;
      end
   end

   always_ff @(posedge sclk or posedge s_rst) begin
      if (s_rst) begin
         r_cnt    <= '0;
         r_debt   <= '0;
         r_ovf    <= 1'b0;
         r_state  <= S_IDLE;
         r_cmd    <= CMD_NOP;
         r_wait   <= '0;
         r_n      <= '0;
         r_issued <= '0;
      end else begin
         r_cnt <= (!flag_init_end || w_tick) ? '0 : r_cnt + 1'b1;
         if (!flag_init_end) begin
            r_debt <= '0;
            r_ovf  <= 1'b0;
         end else begin
            r_debt <= DEBT_W'(w_debt_calc);
            if (w_ovf_set) r_ovf <= 1'b1;
         end
         r_state <= w_state_next;
         r_cmd   <= (w_state_next == S_PRE)  ? CMD_PRE  :
                    (w_state_next == S_AREF) ? CMD_AREF : CMD_NOP;
         r_wait  <= (w_state_next == r_state) ? r_wait + 1'b1 : '0;
         if (w_grant)
            r_n <= (int'(r_debt) < AREF_NUM) ? N_W'(r_debt) : N_W'(AREF_NUM);
         // r_issued counts AREFs including the one currently on the bus.
         if (w_state_next == S_AREF)
            r_issued <= (r_state == S_IDLE) ? N_W'(1) : r_issued + 1'b1;
         else if (r_state == S_IDLE)
            r_issued <= '0;
      end
   end

   assign ref_req      = (r_state == S_IDLE) && (r_debt != '0);
   assign ref_urgent   = (int'(r_debt) >= URGENT_TH);
   assign ref_ovf      = r_ovf;
   assign flag_ref_end = (r_state == S_DONE);
   assign ref_debt     = r_debt;
   assign aref_cmd     = r_cmd;
   assign sdram_addr   = ADDR_W'(1 << 10);
endmodule

// File: doc/sdram_aref_sched.md
# sdram_aref_sched

Parametrised SDRAM auto-refresh scheduler for the SDRAM controller, sitting beside the init, write and read sub-blocks under the top-level arbiter. It generates refresh requests from an interval counter and tracks postponed refreshes as a saturating debt. On each grant it issues a burst of AREF commands with programmable tRP/tRFC spacing, optionally preceded by PRECHARGE ALL. It flags urgency and overflow so the arbiter can pre-empt long write/read bursts.

## Interface
Parameters:
- REF_INTERVAL, 1500: sclk cycles between refresh ticks (15 us at 100 MHz); must be ≥ 2
- AREF_NUM, 1: maximum AREF commands issued per grant; must be ≥ 1
- T_RP, 2: cycles from PRE to next command; must be ≥ 1
- T_RFC, 7: cycles from AREF to next command; must be ≥ 1
- MAX_DEBT, 8: debt saturation limit; must be ≥ 2
- URGENT_TH, 6: debt level at or above which ref_urgent asserts; must be ≤ MAX_DEBT
- ADDR_W, 13: SDRAM address width; must be ≥ 11

Ports:
- sclk  in  1  controller clock
- s_rst  in  1  asynchronous, active-high reset
- flag_init_end  in  1  level, high once SDRAM init has completed
- ref_en  in  1  arbiter grant, sampled only in IDLE while ref_req=1
- ref_req  out  1  refresh pending
- ref_urgent  out  1  debt ≥ URGENT_TH
- ref_ovf  out  1  sticky; a tick arrived while debt=MAX_DEBT
- flag_ref_end  out  1  one-cycle pulse when the grant's sequence completes
- ref_debt  out  $clog2(MAX_DEBT+1)  current outstanding refresh count
- aref_cmd  out  4  {CS_n,RAS_n,CAS_n,WE_n}: NOP 4'b0111, PRE 4'b0010, AREF 4'b0001
- sdram_addr  out  ADDR_W  constant, bit 10 = 1 and all other bits 0

## Operation
- Interval counter, width $clog2(REF_INTERVAL):
  - Counts only while flag_init_end=1; held at 0 otherwise.
  - At REF_INTERVAL-1 it wraps to 0 and produces a one-cycle tick.
- Debt register:
  - tick: +1, saturating at MAX_DEBT; a tick at saturation sets ref_ovf.
  - DONE: −n, where n is the number of AREFs issued in the sequence.
  - tick and DONE in the same cycle: debt − n + 1.
  - flag_init_end=0 clears debt and ref_ovf. A sequence already in progress still completes.
- ref_req = (state==IDLE) && (debt≠0). ref_urgent = debt ≥ URGENT_TH. Both are combinational from registers.
- n is latched at grant as min(debt, AREF_NUM).
- ref_en while ref_req=0 or outside IDLE is ignored.
- FSM states: IDLE, PRE, PRE_WAIT, AREF, AREF_WAIT, DONE.
  - IDLE → PRE (macro defined) or AREF (macro undefined) when ref_en && ref_req.
  - PRE → PRE_WAIT. PRE_WAIT holds T_RP−1 cycles (skipped if T_RP=1), then → AREF.
  - AREF → AREF_WAIT. AREF_WAIT holds T_RFC−1 cycles (skipped if T_RFC=1).
  - After AREF_WAIT: → AREF if issued count < n, else → DONE.
  - DONE → IDLE.
- aref_cmd is registered: PRE in state PRE, AREF in state AREF, NOP in every other state.
- flag_ref_end is high exactly in DONE.
- Reset values: state IDLE, aref_cmd NOP, debt 0, counter 0, ref_req 0, ref_urgent 0, ref_ovf 0, flag_ref_end 0.
- Reset mid-sequence aborts immediately to these values.

## Timing
- Grant sampled at edge T. ref_req drops in cycle T+1. First command (PRE or AREF) appears in cycle T+1.
- Sequence length from T+1 to DONE inclusive: n·T_RFC + 1, plus T_RP when PRE is compiled in.
- Example, macro on, defaults, n=1:
  - PRE at T+1, NOP at T+2, AREF at T+3, NOP at T+4..T+9.
  - flag_ref_end at T+10. ref_req may reassert at T+11.
- First tick: REF_INTERVAL cycles after flag_init_end rises.
- ref_ovf stays set until reset or flag_init_end=0.

## Configuration
- SDRAM_AREF_PREALL_EN defined: every sequence starts with PRE (A10=1, all banks) followed by T_RP−1 NOPs. The arbiter may grant with rows open.
- Undefined: PRE and PRE_WAIT are unreachable and the sequence starts at AREF. The arbiter must guarantee all banks are idle before granting.

## Test plan
- Defaults, macro on, flag_init_end=1 at cycle 0 → ref_req rises at cycle 1500. Grant at T → PRE at T+1, AREF at T+3, flag_ref_end at T+10, debt returns to 0.
- Macro off, defaults → AREF at T+1, NOPs T+2..T+7, flag_ref_end at T+8.
- AREF_NUM=4, grant withheld for 3 ticks (debt=3) → three AREFs spaced 7 cycles apart, then debt=0.
- Grant withheld for 9 ticks, MAX_DEBT=8 → ref_urgent from debt 6, debt saturates at 8, ref_ovf=1 on the 9th tick.
- Tick coinciding with DONE at debt=1, n=1 → debt stays 1 and ref_req reasserts the cycle after DONE.
- s_rst pulsed in AREF_WAIT → aref_cmd=NOP and state IDLE immediately. ref_ovf=0, debt=0.
